// File: rtl/seg7_digit_decoder_if.sv
// Digit-decoder bus: code and control in, segments and ripple-blank out.
// The driver side uses master, the decoder uses slave.
interface seg7_digit_decoder_if;
  logic       en;
  logic [3:0] digit;
  logic       blank;
  logic       lamp_test;
  logic       rb_in;
  logic [6:0] seg;
  logic       rb_out;

  modport master (
    output en,
    output digit,
    output blank,
    output lamp_test,
    output rb_in,
    input  seg,
    input  rb_out
  );

  modport slave (
    input  en,
    input  digit,
    input  blank,
    input  lamp_test,
    input  rb_in,
    output seg,
    output rb_out
  );
endinterface

// File: rtl/seg7_digit_decoder.sv
// Registered BCD/hex to seven-segment decoder for one display digit,
// with lamp test, blanking, polarity select and ripple-blank chaining.
module seg7_digit_decoder #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_EN     = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  seg7_digit_decoder_if.slave  bus
);

  localparam logic [6:0] POL  = {7{ACTIVE_LOW}};
  localparam logic [6:0] DASH = 7'h40;

  logic [6:0] glyph;
  logic [6:0] pat_d;
  logic [6:0] seg_d;
  logic [6:0] seg_q;
  logic       rb_d;
  logic       rb_q;
  logic       zero;

  assign zero = (bus.digit == 4'h0);

  always_comb begin
    glyph = DASH;
    unique case (bus.digit)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = HEX_EN ? 7'h77 : DASH;
      4'hB: glyph = HEX_EN ? 7'h7C : DASH;
      4'hC: glyph = HEX_EN ? 7'h39 : DASH;
      4'hD: glyph = HEX_EN ? 7'h5E : DASH;
      4'hE: glyph = HEX_EN ? 7'h79 : DASH;
      4'hF: glyph = HEX_EN ? 7'h71 : DASH;
      default: glyph = DASH;
    endcase
  end

  // Arms are made mutually exclusive so lamp test beats blank beats ripple.
  always_comb begin
    pat_d = glyph;
    rb_d  = 1'b0;
    unique case (1'b1)
      bus.lamp_test: begin
        pat_d = 7'h7F;
      end
      (!bus.lamp_test && bus.blank): begin
        pat_d = 7'h00;
      end
      (!bus.lamp_test && !bus.blank && bus.rb_in && zero): begin
        pat_d = 7'h00;
        rb_d  = 1'b1;
      end
      default: begin
        pat_d = glyph;
      end
    endcase
    seg_d = pat_d ^ POL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= POL;
      rb_q  <= 1'b0;
    end else if (bus.en) begin
      seg_q <= seg_d;
      rb_q  <= rb_d;
    end
  end

  assign bus.seg    = seg_q;
  assign bus.rb_out = rb_q;

endmodule

// File: tb/tb_seg7_digit_decoder.sv
// Bench: three decoder variants driven in lockstep, checked against
// a table-driven reference model of the display rules.
module tb_seg7_digit_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] digit;
  logic       blank;
  logic       lamp;
  logic       rbi;

  int compared;
  int mismatched;

  logic [6:0] dec_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [6:0] hex_tab [0:5] = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79,
                                7'h71};

  bit cfg_hex [0:2] = '{1'b1, 1'b0, 1'b1};
  bit cfg_al  [0:2] = '{1'b0, 1'b0, 1'b1};

  logic [6:0] exp_seg [0:2];
  logic       exp_rb  [0:2];
  logic [6:0] act_seg [0:2];
  logic       act_rb  [0:2];

  seg7_digit_decoder_if b0 ();
  seg7_digit_decoder_if b1 ();
  seg7_digit_decoder_if b2 ();

  assign b0.en = en;  assign b0.digit = digit;
  assign b0.blank = blank;  assign b0.lamp_test = lamp;
  assign b0.rb_in = rbi;
  assign b1.en = en;  assign b1.digit = digit;
  assign b1.blank = blank;  assign b1.lamp_test = lamp;
  assign b1.rb_in = rbi;
  assign b2.en = en;  assign b2.digit = digit;
  assign b2.blank = blank;  assign b2.lamp_test = lamp;
  assign b2.rb_in = rbi;

  assign act_seg[0] = b0.seg;  assign act_rb[0] = b0.rb_out;
  assign act_seg[1] = b1.seg;  assign act_rb[1] = b1.rb_out;
  assign act_seg[2] = b2.seg;  assign act_rb[2] = b2.rb_out;

  seg7_digit_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  seg7_digit_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  seg7_digit_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] shape(int d, bit hx);
    if (d < 10) return dec_tab[d];
    if (hx) return hex_tab[d - 10];
    return 7'h40;
  endfunction

  // Reference: what one edge does to a display of the given flavour.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic [6:0] mask;
      logic [6:0] p;
      logic       r;
      mask = cfg_al[k] ? 7'h7F : 7'h00;
      r = 1'b0;
      if (lamp) p = 7'h7F;
      else if (blank) p = 7'h00;
      else if (rbi && digit == 4'd0) begin
        p = 7'h00;
        r = 1'b1;
      end else p = shape(int'(digit), cfg_hex[k]);
      if (!rst_n) begin
        exp_seg[k] = mask;
        exp_rb[k]  = 1'b0;
      end else if (en) begin
        exp_seg[k] = p ^ mask;
        exp_rb[k]  = r;
      end
    end
  endtask

  task automatic chk(string tag, logic [6:0] obs, logic [6:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.seg%0d", tag, k), act_seg[k], exp_seg[k]);
      chk($sformatf("%s.rb%0d", tag, k), {6'd0, act_rb[k]},
          {6'd0, exp_rb[k]});
    end
  endtask

  task automatic step(input logic r, input logic e, input int d,
                      input logic bl, input logic lt, input logic rb);
    @(negedge clk);
    rst_n = r;  en = e;  digit = 4'(d);
    blank = bl;  lamp = lt;  rbi = rb;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;  en = 1'b1;  digit = 4'd8;
    blank = 1'b0;  lamp = 1'b0;  rbi = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_seg[k] = 7'hxx;
      exp_rb[k]  = 1'bx;
    end

    // reset with digit=8 pending, two cycles
    step(0, 1, 8, 0, 0, 0);  check_all("rst_a");
    chk("rst_lit0", act_seg[0], 7'h00);
    chk("rst_lit2", act_seg[2], 7'h7F);
    step(0, 1, 8, 0, 0, 0);  check_all("rst_b");

    // full sweep of codes
    for (int d = 0; d < 16; d++) begin
      step(1, 1, d, 0, 0, 0);
      check_all($sformatf("sweep%0d", d));
    end
    chk("sweep15_hex", act_seg[0], 7'h71);
    chk("sweep15_dash", act_seg[1], 7'h40);

    // polarity
    step(1, 1, 1, 0, 0, 0);  check_all("pol1");
    chk("pol1_lit", act_seg[2], 7'h79);
    step(1, 1, 8, 0, 0, 0);  check_all("pol8");
    chk("pol8_lit", act_seg[2], 7'h00);

    // priority
    step(1, 1, 5, 1, 1, 0);  check_all("pri_lt");
    chk("pri_lt_lit", act_seg[0], 7'h7F);
    step(1, 1, 5, 1, 0, 0);  check_all("pri_bl");
    chk("pri_bl_lit", act_seg[0], 7'h00);
    step(1, 1, 5, 0, 0, 0);  check_all("pri_none");
    chk("pri_none_lit", act_seg[0], 7'h6D);

    // ripple blank
    step(1, 1, 0, 0, 0, 1);  check_all("rb_zero");
    chk("rb_zero_lit", {6'd0, act_rb[0]}, 7'h01);
    step(1, 1, 3, 0, 0, 1);  check_all("rb_three");
    step(1, 1, 0, 0, 0, 0);  check_all("rb_off");
    chk("rb_off_lit", act_seg[0], 7'h3F);

    // hold
    step(1, 1, 2, 0, 0, 0);  check_all("hold_load");
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 9, 0, 0, 0);
      check_all($sformatf("hold%0d", i));
      chk($sformatf("hold%0d_lit", i), act_seg[0], 7'h5B);
    end
    step(1, 1, 9, 0, 0, 0);  check_all("hold_rel");
    chk("hold_rel_lit", act_seg[0], 7'h6F);

    // mid-stream reset, then first edge loads normally
    step(0, 1, 4, 0, 0, 0);  check_all("mid_rst");
    step(1, 1, 4, 0, 0, 0);  check_all("post_rst");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int d;
      d = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) d = 0;
      step(($urandom_range(0, 39) != 0),
           ($urandom_range(0, 3) != 0),
           d,
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)));
      check_all($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_digit_decoder.md
Name: seg7_digit_decoder

Overview:
- Registered BCD/hex-to-seven-segment decoder for one display digit.
- Six instances, one per digit (H10, H1, M10, M1, S10, S1), sit behind the clock's binary-to-BCD split and drive the board's seven-segment displays.
- Supports:
  - optional hex glyphs
  - selectable segment polarity
  - blanking
  - lamp test
  - ripple-blank (leading-zero suppression) chaining

Parameters:
- ACTIVE_LOW, default 0: 1 inverts all segment outputs, for common-anode boards.
- HEX_EN, default 1: 1 shows A,b,C,d,E,F for codes 10-15; 0 shows a dash (segment g only) for codes 10-15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- en  in  1  load enable; outputs update only when high
- digit  in  4  digit code 0-15
- blank  in  1  force all segments off
- lamp_test  in  1  force all segments on
- rb_in  in  1  ripple-blank in; suppress a zero digit
- seg  out  7  segments, bit order {g,f,e,d,c,b,a}, a = seg[0]
- rb_out  out  1  high when this digit is being zero-suppressed

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst_n is synchronous and active-low.
  - All state changes occur on the rising edge of clk.
- Outputs are registered; latency is 1 cycle from a sampled input to seg/rb_out.
- Reset: when rst_n=0 at an edge:
  - seg = all segments off: 7'h00 if ACTIVE_LOW=0, 7'h7F if ACTIVE_LOW=1.
  - rb_out = 0.
  - Reset has priority over en and every other input.
- When en=0 (and not in reset), seg and rb_out hold their values.
- When en=1, the next value is chosen by this priority:
  1. lamp_test=1: pattern 7'h7F, rb_out=0.
  2. blank=1: pattern 7'h00, rb_out=0.
  3. rb_in=1 and digit==0: pattern 7'h00, rb_out=1.
  4. Otherwise: decoded glyph, rb_out=0.
- Glyph table (active-high, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - HEX_EN=1: 10=77, 11=7C, 12=39, 13=5E, 14=79, 15=71
  - HEX_EN=0: codes 10-15 give 40 (dash)
- Output polarity: seg = pattern when ACTIVE_LOW=0; seg = ~pattern when ACTIVE_LOW=1. This applies to the reset value, the blank pattern and the lamp-test pattern.
- Ripple-blank chaining:
  - Connect rb_out of a more-significant digit to rb_in of the next less-significant digit.
  - The chain therefore suppresses consecutive leading zeros.
  - Tie rb_in of the least-significant digit low so "0" always displays.
- rb_out is derived from the current cycle's rb_in/digit and carries the same 1-cycle latency as seg.
- All inputs are sampled only at clock edges. There is no combinational path from input to output.
- No X propagation: every 4-bit code maps to a defined glyph.
- Reset asserted mid-stream overrides the pending update on that edge. The first edge after rst_n rises, with en=1, loads normally.

Test Plan:
- Reset: rst_n=0 for 2 cycles with digit=8, en=1 -> seg=7'h00 (ACTIVE_LOW=0) / 7'h7F (ACTIVE_LOW=1), rb_out=0; both hold through reset.
- Sweep: digit 0..15 with en=1, HEX_EN=1, ACTIVE_LOW=0 -> one cycle later seg = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71. Repeat with HEX_EN=0 -> codes 10-15 give 40.
- Polarity: ACTIVE_LOW=1, digit=1 -> seg=7'h79. digit=8 -> seg=7'h00.
- Priority: digit=5 with lamp_test=1 and blank=1 -> seg=7F. With lamp_test=0, blank=1 -> seg=00. With both 0 -> seg=6D.
- Ripple-blank: rb_in=1, digit=0 -> seg=00, rb_out=1. rb_in=1, digit=3 -> seg=4F, rb_out=0. rb_in=0, digit=0 -> seg=3F, rb_out=0.
- Hold: load digit=2 (seg=5B), then en=0 with digit=9 for 3 cycles -> seg stays 5B. Re-assert en -> seg=6F on the next cycle.
